// File: rtl/pc_pkg.sv
// Shared encodings and defaults for the fetch-stage PC generator.
package pc_pkg;

  localparam logic [1:0] REDIR_NONE = 2'd0;
  localparam logic [1:0] REDIR_BR   = 2'd1;
  localparam logic [1:0] REDIR_JR   = 2'd2;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  // Redirect kinds; bit1 set marks the trap class (real trap or converted misalign).
  localparam logic [1:0] KIND_BR   = 2'd0;
  localparam logic [1:0] KIND_JR   = 2'd1;
  localparam logic [1:0] KIND_TRAP = 2'd2;
  localparam logic [1:0] KIND_MIS  = 2'd3;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

  function automatic logic is_trap_kind(input logic [1:0] kind);
    return (kind == KIND_TRAP) || (kind == KIND_MIS);
  endfunction

endpackage

// File: rtl/pc_redir_buf.sv
// Pending-redirect register: captures redirects during a stall; a held trap
// is never displaced by a branch or jump-register redirect.
module pc_redir_buf
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [1:0]      kind,
  input  logic [XLEN-1:0] target,
  input  logic            hold,
  output logic            pend_valid,
  output logic [1:0]      pend_kind,
  output logic [XLEN-1:0] pend_target
);

  logic take;

  // Accept a new entry unless it would push out a held trap.
  always_comb begin
    take = hold && valid &&
           !(pend_valid && is_trap_kind(pend_kind) && !is_trap_kind(kind));
  end

  // Pending entry lives only while hold is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_kind   <= KIND_BR;
      pend_target <= '0;
    end else if (!hold) begin
      pend_valid  <= 1'b0;
    end else if (take) begin
      pend_valid  <= 1'b1;
      pend_kind   <= kind;
      pend_target <= target;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: next-PC selection, fetch handshake, stall-time
// redirect buffering and misaligned-target to trap conversion.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              IALIGN    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            pc_ready,
  input  logic [1:0]      redir_sel,
  input  logic [XLEN-1:0] pc_br,
  input  logic [XLEN-1:0] alu_out,
  input  logic            trap_req,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr
);

  localparam logic CHK_BIT1 = (IALIGN == 4);

  state_t          state_q, state_d;
  logic            new_valid;
  logic [1:0]      new_kind;
  logic [XLEN-1:0] new_target, jr_target;
  logic            pend_valid;
  logic [1:0]      pend_kind;
  logic [XLEN-1:0] pend_target;
  logic            apply;
  logic [1:0]      app_kind;
  logic [XLEN-1:0] app_target;
  logic [XLEN-1:0] pc_d, maddr_d;
  logic            valid_d, flush_d, mis_d;

  // Decode this cycle's redirect request, converting misaligned targets to traps.
  always_comb begin
    new_valid  = 1'b0;
    new_kind   = KIND_BR;
    new_target = '0;
    jr_target  = {alu_out[XLEN-1:1], 1'b0};
    if (trap_req) begin
      new_valid  = 1'b1;
      new_kind   = KIND_TRAP;
      new_target = TRAP_VEC;
    end else if (redir_sel == REDIR_JR) begin
      new_valid  = 1'b1;
      new_target = jr_target;
      new_kind   = (CHK_BIT1 && jr_target[1]) ? KIND_MIS : KIND_JR;
    end else if (redir_sel == REDIR_BR) begin
      new_valid  = 1'b1;
      new_target = pc_br;
      new_kind   = (CHK_BIT1 && pc_br[1]) ? KIND_MIS : KIND_BR;
    end else begin
      new_valid  = 1'b0;
    end
  end

  pc_redir_buf #(.XLEN(XLEN)) u_redir_buf (
    .clk         (clk),
    .rst         (rst),
    .valid       (new_valid && (state_q != S_BOOT)),
    .kind        (new_kind),
    .target      (new_target),
    .hold        (hold),
    .pend_valid  (pend_valid),
    .pend_kind   (pend_kind),
    .pend_target (pend_target)
  );

  // FSM next state and next register values.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    valid_d    = pc_valid;
    flush_d    = 1'b0;
    mis_d      = 1'b0;
    maddr_d    = misalign_addr;
    apply      = 1'b0;
    app_kind   = new_kind;
    app_target = new_target;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        valid_d = 1'b1;
      end
      S_RUN: begin
        if (hold) begin
          state_d = new_valid ? S_PEND : S_RUN;
        end else if (new_valid) begin
          apply = 1'b1;
        end else if (pc_valid && pc_ready) begin
          pc_d = pc + XLEN'(IALIGN);
        end else begin
          pc_d = pc;
        end
      end
      S_PEND: begin
        if (hold) begin
          state_d = S_PEND;
        end else begin
          state_d = S_RUN;
          apply   = pend_valid || new_valid;
          // A fresh redirect wins unless the pending entry is a trap and the fresh one is not.
          if (pend_valid &&
              !(new_valid && !(is_trap_kind(pend_kind) && !is_trap_kind(new_kind)))) begin
            app_kind   = pend_kind;
            app_target = pend_target;
          end else begin
            app_kind   = new_kind;
            app_target = new_target;
          end
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
    if (apply) begin
      flush_d = 1'b1;
      pc_d    = is_trap_kind(app_kind) ? TRAP_VEC : app_target;
      if (app_kind == KIND_MIS) begin
        mis_d   = 1'b1;
        maddr_d = app_target;
      end else begin
        mis_d   = 1'b0;
      end
    end else begin
      flush_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc            <= RESET_VEC;
      pc_valid      <= 1'b0;
      flush_o       <= 1'b0;
      misalign_o    <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state_q       <= state_d;
      pc            <= pc_d;
      pc_valid      <= valid_d;
      flush_o       <= flush_d;
      misalign_o    <= mis_d;
      misalign_addr <= maddr_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes expected handshakes, monitors pop and compare.
module tb_pc_gen;

  typedef struct packed {
    logic [31:0] pc;
    logic        flush;
    logic        mis;
    logic [31:0] maddr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, hold, pc_ready, trap_req, rdy_b;
  logic [1:0]  redir_sel;
  logic [31:0] pc_br, alu_out;
  logic [31:0] pc, misalign_addr, pc_b, maddr_b;
  logic        pc_valid, flush_o, misalign_o, valid_b, flush_b, mis_b;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .hold(hold), .pc_ready(pc_ready), .redir_sel(redir_sel),
    .pc_br(pc_br), .alu_out(alu_out), .trap_req(trap_req), .pc(pc), .pc_valid(pc_valid),
    .flush_o(flush_o), .misalign_o(misalign_o), .misalign_addr(misalign_addr)
  );

  pc_gen #(.RESET_VEC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .hold(1'b0), .pc_ready(rdy_b), .redir_sel(2'd0),
    .pc_br(32'h0), .alu_out(32'h0), .trap_req(1'b0), .pc(pc_b), .pc_valid(valid_b),
    .flush_o(flush_b), .misalign_o(mis_b), .misalign_addr(maddr_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] p, input logic f, input logic m, input logic [31:0] ma);
    qa.push_back('{pc: p, flush: f, mis: m, maddr: ma});
  endtask

  task automatic cyc(input logic h, input logic r, input logic [1:0] s,
                     input logic [31:0] br, input logic [31:0] alu, input logic t);
    hold = h; pc_ready = r; redir_sel = s; pc_br = br; alu_out = alu; trap_req = t;
    @(posedge clk);
    #1;
  endtask

  // Monitor for the main instance: every accepted PC must match the next expectation.
  always @(negedge clk) begin
    if (!rst && pc_valid && pc_ready) begin
      exp_t e;
      checks++;
      if (qa.size() == 0) begin
        $display("FAIL handshake_a: unexpected pc %h", pc);
      end else begin
        e = qa.pop_front();
        if (pc === e.pc && flush_o === e.flush && misalign_o === e.mis && misalign_addr === e.maddr)
          passed++;
        else
          $display("FAIL handshake_a: got pc=%h flush=%b mis=%b maddr=%h expected pc=%h flush=%b mis=%b maddr=%h",
                   pc, flush_o, misalign_o, misalign_addr, e.pc, e.flush, e.mis, e.maddr);
      end
    end
  end

  // Monitor for the wrap-around instance.
  always @(negedge clk) begin
    if (!rst && valid_b && rdy_b) begin
      exp_t e;
      checks++;
      if (qb.size() == 0) begin
        $display("FAIL handshake_b: unexpected pc %h", pc_b);
      end else begin
        e = qb.pop_front();
        if (pc_b === e.pc && flush_b === e.flush && mis_b === e.mis && maddr_b === e.maddr)
          passed++;
        else
          $display("FAIL handshake_b: got pc=%h flush=%b mis=%b expected pc=%h flush=%b mis=%b",
                   pc_b, flush_b, mis_b, e.pc, e.flush, e.mis);
      end
    end
  end

  initial begin
    rst = 1'b1; rdy_b = 1'b0;
    cyc(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", {31'd0, pc_valid}, 32'd0);
    chk("reset_flush", {31'd0, flush_o}, 32'd0);
    chk("reset_mis", {31'd0, misalign_o}, 32'd0);
    chk("reset_maddr", misalign_addr, 32'h0);
    chk("reset_pc_b", pc_b, 32'hFFFF_FFF8);

    rst = 1'b0; rdy_b = 1'b1;
    qb.push_back('{pc: 32'hFFFF_FFF8, flush: 1'b0, mis: 1'b0, maddr: 32'h0});
    qb.push_back('{pc: 32'hFFFF_FFFC, flush: 1'b0, mis: 1'b0, maddr: 32'h0});
    qb.push_back('{pc: 32'h0000_0000, flush: 1'b0, mis: 1'b0, maddr: 32'h0});
    qb.push_back('{pc: 32'h0000_0004, flush: 1'b0, mis: 1'b0, maddr: 32'h0});
    chk("boot_valid", {31'd0, pc_valid}, 32'd0);
    cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      push(32'(i * 4), 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    end
    rdy_b = 1'b0;
    cyc(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);

    // trap beats a same-cycle branch
    push(32'h10, 1'b0, 1'b0, 32'h0);  cyc(1'b0, 1'b1, 2'd1, 32'h200, 32'h0, 1'b1);
    push(32'h100, 1'b1, 1'b0, 32'h0); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    push(32'h104, 1'b0, 1'b0, 32'h0); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);

    // newer pending redirect overwrites an older jump-register one
    cyc(1'b1, 1'b0, 2'd2, 32'h0, 32'h301, 1'b0);
    cyc(1'b1, 1'b0, 2'd1, 32'h400, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    push(32'h108, 1'b0, 1'b0, 32'h0); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    push(32'h400, 1'b1, 1'b0, 32'h0); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    push(32'h404, 1'b0, 1'b0, 32'h0); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);

    // pending trap is sticky
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 2'd1, 32'h400, 32'h0, 1'b0);
    push(32'h408, 1'b0, 1'b0, 32'h0); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    push(32'h100, 1'b1, 1'b0, 32'h0); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    push(32'h104, 1'b0, 1'b0, 32'h0); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);

    // misaligned branch becomes a trap
    push(32'h108, 1'b0, 1'b0, 32'h0);   cyc(1'b0, 1'b1, 2'd1, 32'h202, 32'h0, 1'b0);
    push(32'h100, 1'b1, 1'b1, 32'h202); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    push(32'h104, 1'b0, 1'b0, 32'h202); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);

    // jump-register clears bit0
    push(32'h108, 1'b0, 1'b0, 32'h202); cyc(1'b0, 1'b1, 2'd2, 32'h0, 32'h501, 1'b0);
    push(32'h500, 1'b1, 1'b0, 32'h202); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    push(32'h504, 1'b0, 1'b0, 32'h202); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);

    // redirect applies even when fetch is not ready
    cyc(1'b0, 1'b0, 2'd1, 32'h600, 32'h0, 1'b0);
    push(32'h600, 1'b1, 1'b0, 32'h202); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    push(32'h604, 1'b0, 1'b0, 32'h202); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);

    // reset while a redirect is pending
    cyc(1'b1, 1'b0, 2'd1, 32'h700, 32'h0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    chk("pend_rst_pc", pc, 32'h0);
    chk("pend_rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("pend_rst_maddr", misalign_addr, 32'h0);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    chk("post_rst_flush", {31'd0, flush_o}, 32'd0);
    chk("post_rst_valid", {31'd0, pc_valid}, 32'd1);
    push(32'h0, 1'b0, 1'b0, 32'h0); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    push(32'h4, 1'b0, 1'b0, 32'h0); cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);

    chk("queue_a_drained", 32'(qa.size()), 32'd0);
    chk("queue_b_drained", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage; successor to the single-width PC register.
- Selects the next PC from four sources: sequential increment, branch target, jump-register target, or trap vector.
- Handshakes the current PC to the instruction fetch unit.
- Buffers a redirect that arrives during a stall, and converts misaligned redirect targets into a trap.

Parameters:
XLEN, 32, PC and target width in bits
RESET_VEC, 32'h0000_0000, PC value loaded by reset (XLEN bits)
TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned redirect (XLEN bits)
IALIGN, 4, instruction alignment in bytes; legal values 2 or 4; also the sequential increment

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
hold  in  1  pipeline stall; freezes the PC
pc_ready  in  1  fetch unit accepts the current PC
redir_sel  in  2  0 none, 1 branch (pc_br), 2 jump-register (alu_out), 3 reserved (treated as none)
pc_br  in  XLEN  branch target
alu_out  in  XLEN  jump-register target
trap_req  in  1  trap request; highest priority
pc  out  XLEN  current PC
pc_valid  out  1  pc is valid for fetch
flush_o  out  1  one-cycle pulse: a redirect was applied, so younger stages must be flushed
misalign_o  out  1  one-cycle pulse: a redirect target was misaligned
misalign_addr  out  XLEN  offending target; held until the next misalign event

Behaviour:
- Reset (rst=1 at a clk edge):
  - pc=RESET_VEC, pc_valid=0, flush_o=0, misalign_o=0, misalign_addr=0.
  - Pending register cleared; state=S_BOOT.
  - Reset overrides every other input, including mid-stall and mid-pending.
- FSM states: S_BOOT, S_RUN, S_PEND.
  - S_BOOT -> S_RUN unconditionally after one cycle; pc_valid rises in S_RUN. First valid PC appears 1 cycle after reset deasserts.
  - S_RUN, normal advance: when hold=0 and no redirect, and pc_valid & pc_ready, then pc <= pc + IALIGN. Wraps modulo 2^XLEN with no flag.
  - S_RUN, stall: when hold=0 and no redirect but pc_ready=0, pc is unchanged.
  - S_RUN, redirect with hold=0: applied next cycle whatever pc_ready is. pc <= target, flush_o=1 for exactly that cycle, pc_valid stays 1.
  - S_RUN, redirect with hold=1: target and kind latched into the pending register; state -> S_PEND; pc unchanged.
  - S_PEND, hold=1: a newer redirect overwrites the pending entry, unless a pending trap is held. A trap is never displaced by a branch or jump-register redirect.
  - S_PEND, hold=0: the pending target is applied. If a new redirect arrives in the same cycle, the new one wins, except that a pending trap still beats a new branch or jump-register redirect. flush_o pulses; state -> S_RUN.
- Priority within a cycle: trap_req > redir_sel=2 > redir_sel=1 > sequential.
- Target formation:
  - Trap: TRAP_VEC.
  - Branch: pc_br.
  - Jump-register: alu_out with bit0 forced to 0.
- Misalignment check:
  - Applies to branch and jump-register targets only, on the formed target.
  - IALIGN=4: misaligned if bit1 is set. IALIGN=2: bit0 can never be set, so no misalignment.
  - On detection: pc <= TRAP_VEC, flush_o=1, misalign_o=1, misalign_addr=target.
  - Detection happens in the cycle the redirect is latched, so a pending entry is stored already converted to a trap.
- While hold=1 (any state): pc is frozen and pc_valid keeps its value.
- flush_o and misalign_o are never asserted during reset or in S_BOOT.
- Outputs are registered, with no combinational paths from inputs to outputs.

Decomposition:
- Shared package pc_pkg holds:
  - redir_sel encodings REDIR_NONE, REDIR_BR, REDIR_JR.
  - FSM state encodings.
  - Default RESET_VEC and TRAP_VEC constants.
- One sub-module, pc_redir_buf: the pending-redirect register with trap-sticky overwrite rule. Inputs: valid, kind, target, hold. Outputs: pending valid, kind, target.
- The next-PC mux and FSM stay in pc_gen.

Test Plan:
- Reset, then pc_ready=1 for 4 cycles -> pc_valid=0 in the first cycle after reset; then pc = 0x0, 0x4, 0x8, 0xC.
- XLEN=32, RESET_VEC=0xFFFF_FFF8, IALIGN=4, pc_ready=1 -> pc = 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap, no flag).
- At pc=0x10: redir_sel=1, pc_br=0x200 in the same cycle as trap_req=1 -> next pc=0x100, flush_o=1 for one cycle.
- hold=1 for 3 cycles: redir_sel=2, alu_out=0x301 in hold cycle 1; redir_sel=1, pc_br=0x400 in hold cycle 2; release -> pc=0x400, single flush_o pulse on release.
- hold=1: trap_req in hold cycle 1, redir_sel=1, pc_br=0x400 in hold cycle 2; release -> pc=0x100 (pending trap not displaced).
- IALIGN=4, redir_sel=1, pc_br=0x202 -> pc=0x100, misalign_o=1 for one cycle, misalign_addr=0x202.
- rst asserted while in S_PEND -> pc=RESET_VEC, pending entry discarded, no flush_o after release.
